// File: rtl/rf_pkg.sv
// Constants shared by the register-file writeback path. Also holds the width
// helper for the round-robin pointer.
package rf_pkg;

  localparam int RF_AW = 5;
  localparam int RF_DW = 32;
  localparam logic [RF_AW-1:0] RF_ZERO_REG = '0;

  // Pointer/index width for an n-way arbiter; at least one bit.
  function automatic int ptr_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: scans upward from ptr, wrapping modulo N,
// and grants the first asserted request while en is high.
module rr_arbiter
  import rf_pkg::*;
#(
  parameter int N  = 3,
  parameter int PW = ptr_w(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  input  logic          en,
  output logic [N-1:0]  gnt,
  output logic [PW-1:0] gnt_idx,
  output logic          any_gnt
);

  // ptr is always below N, so a single conditional subtract wraps the sum.
  function automatic int wrap_idx(input int p, input int k);
    int s;
    s = p + k;
    return (s >= N) ? s - N : s;
  endfunction

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    any_gnt = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (en && !any_gnt && req[wrap_idx(int'(ptr), k)]) begin
        gnt[wrap_idx(int'(ptr), k)] = 1'b1;
        gnt_idx = PW'(wrap_idx(int'(ptr), k));
        any_gnt = 1'b1;
      end
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Shares the register file's single write port among NUM_REQ writeback sources.
// Registers the winning write and forwards it to the decode read ports.
module regfile_wb_arbiter
  import rf_pkg::*;
#(
  parameter int NUM_REQ = 3,
  parameter int AW      = RF_AW,
  parameter int DW      = RF_DW,
  parameter int PW      = ptr_w(NUM_REQ)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  wb_stall,
  // Handshake: requester i transfers at a rising edge where req_valid[i] and
  // req_ready[i] are both high; valid/addr/data stay stable until that edge.
  input  logic [NUM_REQ-1:0]    req_valid,
  input  logic [NUM_REQ*AW-1:0] req_addr,
  input  logic [NUM_REQ*DW-1:0] req_data,
  output logic [NUM_REQ-1:0]    req_ready,
  output logic                  rf_we,
  output logic [AW-1:0]         rf_waddr,
  output logic [DW-1:0]         rf_wdata,
  input  logic [AW-1:0]         raddr1,
  input  logic [AW-1:0]         raddr2,
  input  logic [DW-1:0]         rf_rdata1,
  input  logic [DW-1:0]         rf_rdata2,
  output logic [DW-1:0]         rdata1,
  output logic [DW-1:0]         rdata2,
  output logic [15:0]           grant_cnt,
  output logic [PW-1:0]         rr_ptr
);

  logic [PW-1:0]      rr_ptr_q, rr_ptr_d;
  logic               rf_we_q, rf_we_d;
  logic [AW-1:0]      rf_waddr_q, rf_waddr_d;
  logic [DW-1:0]      rf_wdata_q, rf_wdata_d;
  logic [15:0]        grant_cnt_q, grant_cnt_d;

  logic [NUM_REQ-1:0] gnt;
  logic [PW-1:0]      gnt_idx;
  logic               transfer;
  logic               arb_en;
  logic [AW-1:0]      sel_addr;
  logic [DW-1:0]      sel_data;

  // Reset low also blocks grants, so nothing is accepted in a reset cycle.
  assign arb_en = reset_n && !wb_stall;

  rr_arbiter #(
    .N  (NUM_REQ),
    .PW (PW)
  ) u_arb (
    .req     (req_valid),
    .ptr     (rr_ptr_q),
    .en      (arb_en),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .any_gnt (transfer)
  );

  assign req_ready = gnt;

  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) begin
        sel_addr = req_addr[i*AW +: AW];
        sel_data = req_data[i*DW +: DW];
      end
    end
  end

  always_comb begin
    rr_ptr_d    = rr_ptr_q;
    rf_we_d     = 1'b0;
    rf_waddr_d  = rf_waddr_q;
    rf_wdata_d  = rf_wdata_q;
    grant_cnt_d = grant_cnt_q;
    if (transfer) begin
      rr_ptr_d    = (int'(gnt_idx) + 1 >= NUM_REQ) ? '0 : PW'(int'(gnt_idx) + 1);
      // Writes to the zero register are accepted and counted but never issued.
      rf_we_d     = (sel_addr != RF_ZERO_REG);
      rf_waddr_d  = sel_addr;
      rf_wdata_d  = sel_data;
      grant_cnt_d = grant_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rr_ptr_q    <= '0;
      rf_we_q     <= 1'b0;
      rf_waddr_q  <= '0;
      rf_wdata_q  <= '0;
      grant_cnt_q <= '0;
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      rf_we_q     <= rf_we_d;
      rf_waddr_q  <= rf_waddr_d;
      rf_wdata_q  <= rf_wdata_d;
      grant_cnt_q <= grant_cnt_d;
    end
  end

  assign rf_we     = rf_we_q;
  assign rf_waddr  = rf_waddr_q;
  assign rf_wdata  = rf_wdata_q;
  assign grant_cnt = grant_cnt_q;
  assign rr_ptr    = rr_ptr_q;

  // Forward only the write sitting in the output register; rf_we already
  // excludes register 0, the explicit check keeps the rule local to the mux.
  assign rdata1 = (rf_we_q && rf_waddr_q == raddr1 && raddr1 != RF_ZERO_REG) ? rf_wdata_q : rf_rdata1;
  assign rdata2 = (rf_we_q && rf_waddr_q == raddr2 && raddr2 != RF_ZERO_REG) ? rf_wdata_q : rf_rdata2;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: hand-computed vectors covering reset,
// round-robin order, address 0, bypass, stall and reset during traffic.
module tb_regfile_wb_arbiter;

  localparam int N  = 3;
  localparam int AW = 5;
  localparam int DW = 32;
  localparam int PW = 2;

  logic            clk = 1'b0;
  logic            reset_n;
  logic            wb_stall;
  logic [N-1:0]    req_valid;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]    req_ready;
  logic            rf_we;
  logic [AW-1:0]   rf_waddr;
  logic [DW-1:0]   rf_wdata;
  logic [AW-1:0]   raddr1, raddr2;
  logic [DW-1:0]   rf_rdata1, rf_rdata2;
  logic [DW-1:0]   rdata1, rdata2;
  logic [15:0]     grant_cnt;
  logic [PW-1:0]   rr_ptr;

  int checks = 0;
  int errors = 0;

  // clock / reset
  always #5 clk = ~clk;

  regfile_wb_arbiter #(.NUM_REQ(N), .AW(AW), .DW(DW)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .wb_stall  (wb_stall),
    .req_valid (req_valid),
    .req_addr  (req_addr),
    .req_data  (req_data),
    .req_ready (req_ready),
    .rf_we     (rf_we),
    .rf_waddr  (rf_waddr),
    .rf_wdata  (rf_wdata),
    .raddr1    (raddr1),
    .raddr2    (raddr2),
    .rf_rdata1 (rf_rdata1),
    .rf_rdata2 (rf_rdata2),
    .rdata1    (rdata1),
    .rdata2    (rdata2),
    .grant_cnt (grant_cnt),
    .rr_ptr    (rr_ptr)
  );

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_addr[i*AW +: AW] = a;
    req_data[i*DW +: DW] = d;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  logic [N-1:0]  exp_gnt  [6];
  logic [AW-1:0] exp_addr [6];

  initial begin
    #100000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    reset_n   = 1'b0;
    wb_stall  = 1'b0;
    req_valid = '0;
    req_addr  = '0;
    req_data  = '0;
    raddr1    = '0;
    raddr2    = '0;
    rf_rdata1 = '0;
    rf_rdata2 = '0;

    // reset: two cycles low, then a request offered while still in reset
    tick();
    tick();
    check("rst_we",    32'(rf_we), 32'd0);
    check("rst_waddr", 32'(rf_waddr), 32'd0);
    check("rst_wdata", rf_wdata, 32'd0);
    check("rst_cnt",   32'(grant_cnt), 32'd0);
    check("rst_ptr",   32'(rr_ptr), 32'd0);
    req_valid = 3'b111;
    #1;
    check("rst_ready", 32'(req_ready), 32'd0);
    tick();
    check("rst_no_accept_cnt", 32'(grant_cnt), 32'd0);
    check("rst_no_accept_we",  32'(rf_we), 32'd0);
    req_valid = '0;
    reset_n   = 1'b1;

    // single requester
    set_req(0, 5'd5, 32'hDEADBEEF);
    req_valid = 3'b001;
    #1;
    check("single_ready", 32'(req_ready), 32'b001);
    tick();
    req_valid = '0;
    check("single_we",    32'(rf_we), 32'd1);
    check("single_waddr", 32'(rf_waddr), 32'd5);
    check("single_wdata", rf_wdata, 32'hDEADBEEF);
    check("single_cnt",   32'(grant_cnt), 32'd1);
    check("single_ptr",   32'(rr_ptr), 32'd1);
    tick();
    check("idle_we", 32'(rf_we), 32'd0);
    check("idle_waddr_hold", 32'(rf_waddr), 32'd5);

    // full contention, pointer starts at 1
    exp_gnt  = '{3'b010, 3'b100, 3'b001, 3'b010, 3'b100, 3'b001};
    exp_addr = '{5'd11, 5'd12, 5'd10, 5'd11, 5'd12, 5'd10};
    for (int i = 0; i < N; i++) set_req(i, AW'(10 + i), 32'h100 + 32'(i));
    req_valid = 3'b111;
    for (int k = 0; k < 6; k++) begin
      #1;
      check($sformatf("rr_ready_%0d", k), 32'(req_ready), 32'(exp_gnt[k]));
      tick();
      check($sformatf("rr_we_%0d", k),    32'(rf_we), 32'd1);
      check($sformatf("rr_waddr_%0d", k), 32'(rf_waddr), 32'(exp_addr[k]));
    end
    req_valid = '0;
    check("rr_cnt", 32'(grant_cnt), 32'd7);
    check("rr_ptr", 32'(rr_ptr), 32'd1);

    // address 0 from requester 1
    set_req(1, 5'd0, 32'h1234);
    req_valid = 3'b010;
    #1;
    check("a0_ready", 32'(req_ready), 32'b010);
    tick();
    req_valid = '0;
    raddr1    = 5'd0;
    rf_rdata1 = 32'h5555;
    #1;
    check("a0_we",     32'(rf_we), 32'd0);
    check("a0_ptr",    32'(rr_ptr), 32'd2);
    check("a0_cnt",    32'(grant_cnt), 32'd8);
    check("a0_rdata1", rdata1, 32'h5555);

    // bypass of addr 7 from requester 2
    set_req(2, 5'd7, 32'hA5A5A5A5);
    req_valid = 3'b100;
    #1;
    check("byp_ready", 32'(req_ready), 32'b100);
    tick();
    req_valid = '0;
    raddr2    = 5'd7;
    rf_rdata2 = 32'h0;
    raddr1    = 5'd6;
    rf_rdata1 = 32'h11;
    #1;
    check("byp_rdata2",    rdata2, 32'hA5A5A5A5);
    check("byp_rdata1_nm", rdata1, 32'h11);
    raddr1 = 5'd7;
    #1;
    check("byp_rdata1", rdata1, 32'hA5A5A5A5);
    tick();
    check("byp_after_rdata2", rdata2, 32'h0);
    check("byp_cnt", 32'(grant_cnt), 32'd9);
    check("byp_ptr", 32'(rr_ptr), 32'd0);

    // stall for three cycles with two requesters pending
    set_req(0, 5'd3, 32'h33);
    set_req(1, 5'd4, 32'h44);
    wb_stall  = 1'b1;
    req_valid = 3'b011;
    for (int k = 0; k < 3; k++) begin
      #1;
      check($sformatf("stall_ready_%0d", k), 32'(req_ready), 32'd0);
      tick();
      check($sformatf("stall_we_%0d", k),  32'(rf_we), 32'd0);
      check($sformatf("stall_ptr_%0d", k), 32'(rr_ptr), 32'd0);
    end
    check("stall_cnt", 32'(grant_cnt), 32'd9);
    wb_stall = 1'b0;
    #1;
    check("release_ready", 32'(req_ready), 32'b001);
    tick();
    check("release_waddr", 32'(rf_waddr), 32'd3);
    check("release_wdata", rf_wdata, 32'h33);
    check("release_ptr",   32'(rr_ptr), 32'd1);
    check("release_cnt",   32'(grant_cnt), 32'd10);

    // reset mid-operation: transfer at T, reset sampled at T+1
    check("mid_ready", 32'(req_ready), 32'b010);
    tick();
    check("mid_we",    32'(rf_we), 32'd1);
    check("mid_waddr", 32'(rf_waddr), 32'd4);
    check("mid_cnt",   32'(grant_cnt), 32'd11);
    reset_n = 1'b0;
    #1;
    check("mid_rst_ready", 32'(req_ready), 32'd0);
    tick();
    check("mid_rst_we",    32'(rf_we), 32'd0);
    check("mid_rst_cnt",   32'(grant_cnt), 32'd0);
    check("mid_rst_ptr",   32'(rr_ptr), 32'd0);
    check("mid_rst_waddr", 32'(rf_waddr), 32'd0);
    check("mid_rst_ready2", 32'(req_ready), 32'd0);
    tick();
    check("mid_rst_cnt2", 32'(grant_cnt), 32'd0);
    reset_n = 1'b1;
    #1;
    check("post_rst_ready", 32'(req_ready), 32'b001);
    tick();
    req_valid = '0;
    check("post_rst_cnt",   32'(grant_cnt), 32'd1);
    check("post_rst_waddr", 32'(rf_waddr), 32'd3);

    // final report
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/regfile_wb_arbiter.md
# regfile_wb_arbiter

Write-port arbiter and sequencer for the 32x32 register file. It shares the file's single write port between `NUM_REQ` writeback sources (ALU, load unit, mul/div) using round-robin arbitration with a valid/ready handshake. It drives a registered `we`/`waddr`/`wdata` into the register file. It also provides read-after-write bypass for the write that is in flight, so decode sees the correct value one cycle before the array is updated.

## Interface
- `NUM_REQ`, 3: number of writeback requesters, from 2 to 8.
- `AW`, 5: register address width.
- `DW`, 32: data width.
- `clk` in 1: single clock, rising edge.
- `reset_n` in 1: synchronous, active-low reset, sampled on the `clk` rising edge.
- `wb_stall` in 1: when high, no grants are issued.
- `req_valid` in `NUM_REQ`: per-requester write request.
- `req_addr` in `NUM_REQ*AW`: packed destination addresses; requester i occupies bits `[i*AW +: AW]`.
- `req_data` in `NUM_REQ*DW`: packed write data.
- `req_ready` out `NUM_REQ`: one-hot grant, or all zero.
- `rf_we` out 1: register file write enable.
- `rf_waddr` out `AW`: register file write address.
- `rf_wdata` out `DW`: register file write data.
- `raddr1`, `raddr2` in `AW`: decode read addresses.
- `rf_rdata1`, `rf_rdata2` in `DW`: raw register file read data.
- `rdata1`, `rdata2` out `DW`: read data after bypass.
- `grant_cnt` out 16: count of accepted requests, wrapping.

## Operation
- **Handshake:** a transfer on requester i occurs when `req_valid[i] && req_ready[i]` at a rising edge. Requesters hold `valid`/`addr`/`data` stable until that edge.
- **Arbitration:** combinational. Requesters are scanned starting at `rr_ptr`, ascending and wrapping modulo `NUM_REQ`. The first valid requester gets `req_ready`.
- **Ready rules:**
  - `req_ready` is never asserted without the matching `req_valid`.
  - `req_ready` is all zero while `wb_stall` is high or `reset_n` is low.
- **Pointer update:** on a transfer from requester i, `rr_ptr` becomes `(i+1) mod NUM_REQ`. Otherwise it holds.
- **Output register:** on a transfer, the next cycle has `rf_we=1`, `rf_waddr=addr`, `rf_wdata=data`. If there is no transfer, `rf_we=0` and `rf_waddr`/`rf_wdata` hold their old values.
- **Address 0:**
  - A transfer with `addr==0` is accepted: ready is asserted, the pointer advances and the count increments.
  - `rf_we` stays 0 for that transfer.
  - Register 0 is never written.
- **Bypass:**
  - `rdataN = (rf_we && rf_waddr==raddrN && raddrN!=0) ? rf_wdata : rf_rdataN`.
  - The bypass is purely combinational.
  - It covers only the registered write stage. Requests that are valid but not yet granted are not forwarded.
- **Counter:** `grant_cnt` increments by 1 per transfer, including transfers to address 0, and wraps from 0xFFFF to 0.
- **Reset:**
  - When `reset_n` is low at an edge: `rr_ptr=0`, `rf_we=0`, `rf_waddr=0`, `rf_wdata=0`, `grant_cnt=0`.
  - A request presented during the reset cycle is not accepted.
  - A registered write pending when reset is asserted is squashed: `rf_we=0` from the next cycle.

## Timing
- Grant latency is 0 cycles: `req_ready` is asserted in the same cycle as `req_valid` if requester i wins.
- Write latency:
  - Transfer at edge T drives `rf_we`/`rf_waddr`/`rf_wdata` during cycle T..T+1.
  - The register file commits at edge T+1.
- Bypass window: exactly the one cycle during which `rf_we` is high.
- Throughput: one accepted write per cycle while any requester is valid and `wb_stall` is low.
- Fairness: a continuously valid requester waits at most `NUM_REQ-1` grants to others.
- `wb_stall` takes effect combinationally in the same cycle. A write already registered still completes.
- Simultaneous requests to the same address are serialized in round-robin order; the later grant's data wins in the array.

## Structure
- A shared package `rf_pkg` holds the constants `RF_AW=5`, `RF_DW=32` and `RF_ZERO_REG=0`. Parameter defaults refer to these constants.
- One sub-module, `rr_arbiter`, parameterized on `N`:
  - Inputs: `req[N-1:0]`, `ptr`, `en`.
  - Outputs: one-hot `gnt`, binary `gnt_idx`, `any_gnt`.
  - Purely combinational.
- The top level holds the pointer, output register, bypass muxes and counter.

## Test plan
- **Single requester:** reset with `reset_n=0` for 2 cycles, then `req_valid=3'b001`, addr 5, data 0xDEADBEEF.
  - `req_ready=001` in the same cycle.
  - Next cycle: `rf_we=1`, `rf_waddr=5`, `rf_wdata=0xDEADBEEF`.
  - `grant_cnt=1`.
- **Full contention:** hold `req_valid=111` for 6 cycles.
  - Grants in order 001, 010, 100, 001, 010, 100.
  - `grant_cnt=6`.
- **Address 0:** requester 1 with addr 0, data 0x1234.
  - `req_ready=010`.
  - Next cycle `rf_we=0`; `rr_ptr` advances to 2; the count increments.
  - With `raddr1=0`, `rdata1=rf_rdata1`.
- **Bypass:** grant addr 7, data 0xA5A5A5A5, with `raddr2=7` and `rf_rdata2=0` in the following cycle.
  - `rdata2=0xA5A5A5A5` in that cycle only.
  - The cycle after, `rdata2=rf_rdata2`.
- **Stall:** assert `wb_stall` for 3 cycles with `req_valid=011`.
  - `req_ready=000` throughout and `rf_we=0` after the first stall cycle.
  - The pointer is unchanged.
  - On release, the grant goes to the requester at `rr_ptr`.
- **Reset mid-operation:** a transfer at edge T, then `reset_n=0` sampled at T+1.
  - `rf_we=0` after T+1.
  - `grant_cnt=0` and `rr_ptr=0`.
  - No `req_ready` while in reset.
